sram_fifo_arb: RTL
==================

// Module: sram_fifo_arb
// PURPOSE
//  Synchronous FIFO controller over one external single-port SRAM, with req/grant handshakes on both sides.
//  A round-robin arbiter shares the single SRAM port when push and pop contend.
//  Read data is registered and qualified by DoutValid.
//  Also provides level count, programmable almost-full/empty flags and synchronous flush; sits between a producer and consumer.
// PARAMETERS
//  ADDR_SIZE  6   SRAM address width; depth = 2**ADDR_SIZE entries
//  DATA_SIZE  16  data width
//  AF_LEVEL   56  AlmostFull asserted when Count >= AF_LEVEL (1..2**ADDR_SIZE)
//  AE_LEVEL   8   AlmostEmpty asserted when Count <= AE_LEVEL (0..2**ADDR_SIZE-1)
// PORTS
//  Clk          in   1            clock, all state on rising edge
//  nReset       in   1            asynchronous active-low reset
//  Clear        in   1            synchronous flush, highest priority
//  WrReq        in   1            producer push request, held until WrGnt
//  Din          in   DATA_SIZE    push data, valid with WrReq
//  WrGnt        out  1            push accepted this cycle
//  RdReq        in   1            consumer pop request, held until RdGnt
//  RdGnt        out  1            pop accepted this cycle
//  Dout         out  DATA_SIZE    popped data, registered
//  DoutValid    out  1            Dout holds new word (1-cycle pulse)
//  Count        out  ADDR_SIZE+1  words stored, 0..2**ADDR_SIZE
//  Full/Empty   out  1 each       Count==depth / Count==0
//  AlmostFull   out  1            per AF_LEVEL
//  AlmostEmpty  out  1            per AE_LEVEL
//  Addr         out  ADDR_SIZE    SRAM address
//  WData        out  DATA_SIZE    SRAM write data
//  RData        in   DATA_SIZE    SRAM read data, valid same cycle as nOE low
//  nCS/nOE/nWE  out  1 each       SRAM strobes, active low
// BEHAVIOUR
//  Reset (nReset low, async): wr_ptr=rd_ptr=0, Count=0, Empty=1, Full=0, AlmostEmpty=1, AlmostFull=0.
//   Also DoutValid=0, Dout=0, prio=WRITE. WrGnt=RdGnt=0, nCS=nOE=nWE=1 while nReset low.
//   Reset mid-transfer discards all content; there is no partial completion.
//  Pointers: wr_ptr/rd_ptr are ADDR_SIZE+1 bits; the low bits address SRAM and the MSB is the wrap bit.
//   Both wrap modulo 2**(ADDR_SIZE+1).
//   Full when low bits are equal and MSBs differ; Empty when all bits are equal.
//   Count = wr_ptr - rd_ptr (mod 2**(ADDR_SIZE+1)).
//  Eligibility: wr_ok = WrReq & ~Full; rd_ok = RdReq & ~Empty. Flags are registered; grants are combinational from these.
//  Arbitration (one SRAM access per cycle):
//   - only one of wr_ok/rd_ok set: grant it;
//   - both set: grant the side named by prio, then prio flips to the other side;
//   - prio changes only on a contested cycle.
//  Clear=1: WrGnt=RdGnt=0, strobes inactive.
//   Next edge: pointers=0, Count=0, flags as at reset, DoutValid=0. prio is unchanged.
//  SRAM drive (combinational from grants):
//   - WrGnt: Addr=wr_ptr[ADDR_SIZE-1:0], WData=Din, nCS=0, nWE=0, nOE=1;
//   - RdGnt: Addr=rd_ptr[ADDR_SIZE-1:0], nCS=0, nOE=0, nWE=1;
//   - idle: Addr=0, WData=0, all strobes 1. No tristate outputs.
//  Pointer update: wr_ptr+1 on WrGnt, rd_ptr+1 on RdGnt.
//   Count and all flags update on the same edge and are valid the next cycle.
//  Read latency: RData is captured into Dout at the edge ending the RdGnt cycle, and DoutValid=1 for the following cycle.
//   Dout holds its value otherwise.
//  Throughput: 1 access/cycle. Under sustained contention, push and pop each get 1 of every 2 cycles.
//  Boundaries:
//   - WrReq while Full: no grant, no SRAM write, and the request stays pending.
//   - RdReq while Empty: no grant, and DoutValid stays 0.
//   - A pop while Full frees a slot; a push can be granted the next cycle.
//   - Same-cycle write then read of one address is impossible, because grants are exclusive.
// TESTING (ADDR_SIZE=6, DATA_SIZE=16, AF=56, AE=8)
//  1. Reset: nReset=0 asynchronously mid-stream.
//     -> Count=0, Empty=1, AlmostEmpty=1, strobes=1, DoutValid=0, all without waiting for a clock edge.
//  2. Fill: push 0x0000..0x003F.
//     -> Full=1 after the 64th WrGnt; AlmostFull rises at Count=56.
//     -> A 65th WrReq is not granted and nWE stays 1.
//  3. Drain: pop all 64 words.
//     -> Dout = 0x0000..0x003F in order, each with DoutValid one cycle after its RdGnt.
//     -> Empty=1 after the last pop; an extra RdReq is not granted.
//  4. Contention: hold WrReq and RdReq with Count=10 from reset.
//     -> Grants go W,R,W,R..., Count oscillates 10/11, and nCS is 0 every cycle.
//  5. Wrap: perform 200 push/pop pairs.
//     -> Pointers wrap and data stays in order; Full never asserts while Count<64.
//  6. Clear with Count=30 and WrReq held.
//     -> No grant in the Clear cycle; the next cycle shows Count=0, Empty=1, and WrGnt=1.

Source files
------------

// File: rtl/sram_fifo_arb_if.sv
// Handshake and SRAM bus bundle for the SRAM-backed FIFO controller.
// The master side is the environment (producer, consumer, SRAM read data);
// the slave side is the FIFO controller itself.
interface sram_fifo_arb_if #(
   parameter int ADDR_SIZE = 6,
   parameter int DATA_SIZE = 16
);
   logic                 Clear;
   logic                 WrReq;
   logic [DATA_SIZE-1:0] Din;
   logic                 WrGnt;
   logic                 RdReq;
   logic                 RdGnt;
   logic [DATA_SIZE-1:0] Dout;
   logic                 DoutValid;
   logic [ADDR_SIZE:0]   Count;
   logic                 Full;
   logic                 Empty;
   logic                 AlmostFull;
   logic                 AlmostEmpty;
   logic [ADDR_SIZE-1:0] Addr;
   logic [DATA_SIZE-1:0] WData;
   logic [DATA_SIZE-1:0] RData;
   logic                 nCS;
   logic                 nOE;
   logic                 nWE;

   modport master (
      output Clear, WrReq, Din, RdReq, RData,
      input  WrGnt, RdGnt, Dout, DoutValid, Count, Full, Empty,
             AlmostFull, AlmostEmpty, Addr, WData, nCS, nOE, nWE
   );

   modport slave (
      input  Clear, WrReq, Din, RdReq, RData,
      output WrGnt, RdGnt, Dout, DoutValid, Count, Full, Empty,
             AlmostFull, AlmostEmpty, Addr, WData, nCS, nOE, nWE
   );
endinterface

// File: rtl/sram_fifo_arb.sv
// FIFO controller over one single-port SRAM. Push and pop share the SRAM
// port through a round-robin arbiter; grants and SRAM strobes are
// combinational from registered eligibility flags, read data is registered.
module sram_fifo_arb #(
   parameter int ADDR_SIZE = 6,
   parameter int DATA_SIZE = 16,
   parameter int AF_LEVEL  = 56,
   parameter int AE_LEVEL  = 8
) (
   input logic            Clk,
   input logic            nReset,
   sram_fifo_arb_if.slave bus
);
   localparam int PW = ADDR_SIZE + 1;
   localparam logic [PW-1:0] PTR_ONE  = {{ADDR_SIZE{1'b0}}, 1'b1};
   localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
   localparam logic [PW-1:0] AF_CMP   = PW'(AF_LEVEL);
   localparam logic [PW-1:0] AE_CMP   = PW'(AE_LEVEL);

   typedef enum logic {PRIO_WRITE = 1'b0, PRIO_READ = 1'b1} prio_t;

   // Full: same slot index, opposite wrap bit.
   function automatic logic is_full(input logic [PW-1:0] wp, input logic [PW-1:0] rp);
      return (wp[ADDR_SIZE-1:0] == rp[ADDR_SIZE-1:0]) && (wp[ADDR_SIZE] != rp[ADDR_SIZE]);
   endfunction

   logic [PW-1:0]        wr_ptr_r, rd_ptr_r, count_r;
   logic                 full_r, empty_r, af_r, ae_r;
   prio_t                prio_r;
   logic [DATA_SIZE-1:0] dout_r;
   logic                 dout_valid_r;

   logic                 wr_ok_s, rd_ok_s, contested_s;
   logic                 wr_gnt_s, rd_gnt_s;
   logic [PW-1:0]        wr_ptr_nx_s, rd_ptr_nx_s, count_nx_s;
   logic [ADDR_SIZE-1:0] addr_s;
   logic [DATA_SIZE-1:0] wdata_s;
   logic                 ncs_s, noe_s, nwe_s;

   // Arbitration: one SRAM access per cycle, round robin only when both sides are eligible.
   always_comb begin
      wr_ok_s     = bus.WrReq & ~full_r;
      rd_ok_s     = bus.RdReq & ~empty_r;
      contested_s = 1'b0;
      wr_gnt_s    = 1'b0;
      rd_gnt_s    = 1'b0;
      if (!nReset || bus.Clear) begin
         wr_gnt_s = 1'b0;
         rd_gnt_s = 1'b0;
      end else if (wr_ok_s && rd_ok_s) begin
         contested_s = 1'b1;
         if (prio_r == PRIO_WRITE) begin
            wr_gnt_s = 1'b1;
         end else begin
            rd_gnt_s = 1'b1;
         end
      end else begin
         wr_gnt_s = wr_ok_s;
         rd_gnt_s = rd_ok_s;
      end
   end

   // Next pointer values and the level they imply after this cycle's access.
   always_comb begin
      wr_ptr_nx_s = wr_ptr_r;
      rd_ptr_nx_s = rd_ptr_r;
      if (wr_gnt_s) begin
         wr_ptr_nx_s = wr_ptr_r + PTR_ONE;
      end else begin
         wr_ptr_nx_s = wr_ptr_r;
      end
      if (rd_gnt_s) begin
         rd_ptr_nx_s = rd_ptr_r + PTR_ONE;
      end else begin
         rd_ptr_nx_s = rd_ptr_r;
      end
      count_nx_s = wr_ptr_nx_s - rd_ptr_nx_s;
   end

   // SRAM port drive: write, read or idle with all strobes released.
   always_comb begin
      addr_s  = {ADDR_SIZE{1'b0}};
      wdata_s = {DATA_SIZE{1'b0}};
      ncs_s   = 1'b1;
      noe_s   = 1'b1;
      nwe_s   = 1'b1;
      if (wr_gnt_s) begin
         addr_s  = wr_ptr_r[ADDR_SIZE-1:0];
         wdata_s = bus.Din;
         ncs_s   = 1'b0;
         nwe_s   = 1'b0;
      end else if (rd_gnt_s) begin
         addr_s = rd_ptr_r[ADDR_SIZE-1:0];
         ncs_s  = 1'b0;
         noe_s  = 1'b0;
      end else begin
         ncs_s = 1'b1;
      end
   end

   // Pointer, level, flag, priority and read-data state; Clear flushes but keeps prio and Dout.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         wr_ptr_r     <= PTR_ZERO;
         rd_ptr_r     <= PTR_ZERO;
         count_r      <= PTR_ZERO;
         full_r       <= 1'b0;
         empty_r      <= 1'b1;
         af_r         <= 1'b0;
         ae_r         <= 1'b1;
         prio_r       <= PRIO_WRITE;
         dout_r       <= {DATA_SIZE{1'b0}};
         dout_valid_r <= 1'b0;
      end else if (bus.Clear) begin
         wr_ptr_r     <= PTR_ZERO;
         rd_ptr_r     <= PTR_ZERO;
         count_r      <= PTR_ZERO;
         full_r       <= 1'b0;
         empty_r      <= 1'b1;
         af_r         <= 1'b0;
         ae_r         <= 1'b1;
         dout_valid_r <= 1'b0;
      end else begin
         wr_ptr_r     <= wr_ptr_nx_s;
         rd_ptr_r     <= rd_ptr_nx_s;
         count_r      <= count_nx_s;
         full_r       <= is_full(wr_ptr_nx_s, rd_ptr_nx_s);
         empty_r      <= (wr_ptr_nx_s == rd_ptr_nx_s);
         af_r         <= (count_nx_s >= AF_CMP);
         ae_r         <= (count_nx_s <= AE_CMP);
         dout_valid_r <= rd_gnt_s;
         if (contested_s) begin
            prio_r <= (prio_r == PRIO_WRITE) ? PRIO_READ : PRIO_WRITE;
         end else begin
            prio_r <= prio_r;
         end
         if (rd_gnt_s) begin
            dout_r <= bus.RData;
         end else begin
            dout_r <= dout_r;
         end
      end
   end

   assign bus.WrGnt       = wr_gnt_s;
   assign bus.RdGnt       = rd_gnt_s;
   assign bus.Dout        = dout_r;
   assign bus.DoutValid   = dout_valid_r;
   assign bus.Count       = count_r;
   assign bus.Full        = full_r;
   assign bus.Empty       = empty_r;
   assign bus.AlmostFull  = af_r;
   assign bus.AlmostEmpty = ae_r;
   assign bus.Addr        = addr_s;
   assign bus.WData       = wdata_s;
   assign bus.nCS         = ncs_s;
   assign bus.nOE         = noe_s;
   assign bus.nWE         = nwe_s;
endmodule
